stream_mux_arb: RTL

N-channel, parametrised successor to the team's 4:1 combinational mux. It selects one of NUM_CH valid/ready input streams and passes it through a single registered output stage.
- Selection mode is chosen at elaboration: explicit select (MODE=0) or round-robin arbitration (MODE=1).
- The block carries its own embedded concurrent assertions that check mux correctness and handshake protocol.
- It sits between multiple producers and one downstream consumer.

---
 rtl/stream_mux_pkg.sv | 36 +++
 rtl/mux_rr_arbiter.sv | 34 +++
 rtl/stream_mux_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and round-robin search for stream_mux_arb
package stream_mux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   localparam int MAX_CH    = 16;
   localparam int MAX_SEL_W = 4;

   typedef struct packed {
      logic                 found;
      logic [MAX_SEL_W-1:0] idx;
   } rr_pick_t;

   // First valid channel strictly after ptr, wrapping at num_ch.
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]    valid,
                                        input logic [MAX_SEL_W-1:0] ptr,
                                        input int                   num_ch);
      rr_pick_t           res;
      logic [MAX_SEL_W:0] c;
      res = '0;
      for (int k = 1; k <= MAX_CH; k++) begin
         c = {1'b0, ptr} + (MAX_SEL_W+1)'(k);
         if (c >= (MAX_SEL_W+1)'(num_ch))
            c = c - (MAX_SEL_W+1)'(num_ch);
         if (k <= num_ch && !res.found && valid[c[MAX_SEL_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = c[MAX_SEL_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin pointer and grant search for stream_mux_arb
module mux_rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] in_valid,
   input  logic              advance,
   input  logic [SEL_W-1:0]  advance_idx,
   output logic              grant_vld,
   output logic [SEL_W-1:0]  grant_idx
);

   logic [SEL_W-1:0] rr_ptr;
   rr_pick_t         pick;

   always_comb begin
      pick      = rr_pick(MAX_CH'(in_valid), MAX_SEL_W'(rr_ptr), NUM_CH);
      grant_vld = pick.found;
      grant_idx = SEL_W'(pick.idx);
   end

   // Pointer resets to the last channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= SEL_W'(NUM_CH - 1);
      else if (advance)
         rr_ptr <= advance_idx;
   end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel stream mux with explicit or round-robin select and one output register
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   parameter  int MODE   = 0,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SEL_W-1:0]         out_ch
);

   logic              load_en;
   logic              grant_vld;
   logic [SEL_W-1:0]  grant_idx;
   logic [DATA_W-1:0] grant_data;
   logic              xfer;

   assign load_en = !out_valid || out_ready;

   if (MODE == int'(MODE_RR)) begin : g_rr
      mux_rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
         .clk         (clk),
         .rst         (rst),
         .in_valid    (in_valid),
         .advance     (xfer),
         .advance_idx (grant_idx),
         .grant_vld   (grant_vld),
         .grant_idx   (grant_idx)
      );
   end else begin : g_sel
      // sel can exceed NUM_CH-1 when NUM_CH is not a power of two.
      assign grant_vld = (int'(sel) < NUM_CH) && in_valid[sel];
      assign grant_idx = sel;
   end

   always_comb begin
      grant_data = '0;
      in_ready   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_data  = in_data[i*DATA_W +: DATA_W];
            in_ready[i] = !rst && load_en && grant_vld;
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load_en) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data <= grant_data;
            out_ch   <= grant_idx;
         end
      end
   end

   a_onehot_ready: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready))
      else $error("%m: a_onehot_ready violated at %0t", $time);

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      out_valid && !out_ready |=> $stable(out_data) && $stable(out_ch) && out_valid)
      else $error("%m: a_stall_stable violated at %0t", $time);

   a_data_match: assert property (@(posedge clk) disable iff (rst)
      xfer |=> out_data == $past(grant_data) && out_ch == $past(grant_idx))
      else $error("%m: a_data_match violated at %0t", $time);

   a_ch_range: assert property (@(posedge clk) disable iff (rst) out_valid |-> int'(out_ch) < NUM_CH)
      else $error("%m: a_ch_range violated at %0t", $time);

   if (MODE == int'(MODE_RR)) begin : g_fair
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         // Transfers to other channels while channel i waits with valid held.
         logic [SEL_W:0] wait_cnt;
         always_ff @(posedge clk) begin
            if (rst || !in_valid[i] || in_ready[i])
               wait_cnt <= '0;
            else if (xfer)
               wait_cnt <= wait_cnt + (SEL_W+1)'(1);
         end
         a_rr_fair: assert property (@(posedge clk) disable iff (rst) int'(wait_cnt) < NUM_CH)
            else $error("%m: a_rr_fair violated at %0t", $time);
      end
   end

endmodule
